mxint8_to_fp32_unpacker: RTL and testbench

- Decodes one MXINT8 block (one E8M0 shared scale plus BLOCK_SIZE int8 elements) into FP32 values.
- This is the dequantize direction, the inverse of the FP32-to-MXINT8 quantizer path exercised by the fp32/mxint8 stimulus classes.
- Accepts a whole block through a valid/ready handshake and streams LANES FP32 results per beat, so the block needs BLOCK_SIZE/LANES beats.
- Sits between the MX ALU result buffer and the scalar FP32 datapath.

---
 rtl/mxint8_to_fp32_unpacker_pkg.sv | 32 +++
 rtl/mxint8_elem_to_fp32.sv | 53 +++++
 rtl/mxint8_to_fp32_unpacker.sv | 136 +++++++++++++
 tb/tb_mxint8_to_fp32_unpacker.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mxint8_to_fp32_unpacker_pkg.sv
// Shared constants and types for the MXINT8 -> FP32 dequantize path.
package mxint8_to_fp32_unpacker_pkg;

  localparam int MXINT8_ELEMENT_WIDTH   = 8;
  localparam int SCALE_WIDTH            = 8;
  localparam int BLOCK_SIZE             = 32;
  localparam int FLOAT32_EXPONENT_WIDTH = 8;
  localparam int FLOAT32_MANTISSA_WIDTH = 23;
  localparam int MXINT8_FRAC_BITS       = 6;

  localparam logic [SCALE_WIDTH-1:0] E8M0_NAN     = 8'hFF;
  localparam logic [31:0]            FP32_QNAN    = 32'h7FC0_0000;
  localparam logic [31:0]            FP32_POS_INF = 32'h7F80_0000;
  localparam logic [31:0]            FP32_NEG_INF = 32'hFF80_0000;

  // Unpacker control state; exported on the debug port of the top.
  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_STREAM = 1'b1
  } unpack_state_e;

  // Index of the most significant set bit; 0 for a zero input.
  function automatic logic [2:0] lead_one_idx(input logic [7:0] v);
    logic [2:0] idx;
    idx = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (v[i]) idx = 3'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/mxint8_elem_to_fp32.sv
// Converts one int8 (1.6 fixed point) element with an E8M0 shared scale
// into an exact FP32 value. Purely combinational.
module mxint8_elem_to_fp32
  import mxint8_to_fp32_unpacker_pkg::*;
(
  input  logic [7:0]  scale,
  input  logic [7:0]  elem,
  output logic [31:0] fp32
);

  logic [7:0]        w_mag;
  logic [2:0]        w_lead;
  logic signed [9:0] w_exp;
  logic [3:0]        w_norm_shift;
  logic [22:0]       w_mant_norm;
  logic [4:0]        w_sub_shift;
  logic [22:0]       w_mant_sub;

  // -128 negates to 8'h80, which reads correctly as magnitude 128.
  assign w_mag  = elem[7] ? (8'd0 - elem) : elem;
  assign w_lead = lead_one_idx(w_mag);

  // Unbiased value is mag * 2^(S-133); with mag = 1.x * 2^p the biased
  // exponent becomes S + p - 6.
  assign w_exp = $signed({2'b00, scale}) + $signed({7'b0, w_lead})
               - 10'(MXINT8_FRAC_BITS);

  // Shift so the leading one falls just past bit 22 and drops off; what
  // remains is the left-aligned fraction.
  assign w_norm_shift = 4'd8 - {1'b0, w_lead};
  assign w_mant_norm  = {w_mag, 15'b0} << w_norm_shift;

  // Subnormal only when S + p <= 6, so S <= 6 and scale[2:0] is all of S.
  assign w_sub_shift = {2'b00, scale[2:0]} + 5'd16;
  assign w_mant_sub  = {15'b0, w_mag} << w_sub_shift;

  // Select special, normal or subnormal encoding.
  always_comb begin
    fp32 = 32'h0000_0000;
    if (scale == E8M0_NAN) begin
      fp32 = FP32_QNAN;
    end else if (elem == 8'h00) begin
      fp32 = 32'h0000_0000;
    end else if (w_exp >= 10'sd255) begin
      fp32 = elem[7] ? FP32_NEG_INF : FP32_POS_INF;
    end else if (w_exp >= 10'sd1) begin
      fp32 = {elem[7], w_exp[7:0], w_mant_norm};
    end else begin
      fp32 = {elem[7], 8'h00, w_mant_sub};
    end
  end

endmodule

// File: rtl/mxint8_to_fp32_unpacker.sv
// Accepts one MXINT8 block and streams it out as FP32, LANES per beat.
//
// Handshakes: a transfer happens on a rising edge where valid & ready are
// both high. valid never drops and the payload never changes while waiting
// for ready. On the input side, ready is high in IDLE and during the cycle
// the last beat is handed off, so a following block enters with no bubble.
module mxint8_to_fp32_unpacker
  import mxint8_to_fp32_unpacker_pkg::*;
#(
  parameter int BLOCK_SIZE = mxint8_to_fp32_unpacker_pkg::BLOCK_SIZE,
  parameter int LANES      = 4,
  localparam int BEATS     = BLOCK_SIZE / LANES,
  localparam int BEAT_W    = (BEATS > 1) ? $clog2(BEATS) : 1,
  localparam int LANE_W    = (LANES > 1) ? $clog2(LANES) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [7:0]              in_scale,
  input  logic [BLOCK_SIZE*8-1:0] in_elements,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [LANES*32-1:0]     out_data,
  output logic [BEAT_W-1:0]       out_beat,
  output logic                    out_last,
  output logic                    out_nan,
  output logic                    dbg_state
);

  unpack_state_e             r_state;
  unpack_state_e             w_state_nxt;
  logic [7:0]                r_scale;
  logic [BLOCK_SIZE*8-1:0]   r_elems;
  logic [BEAT_W-1:0]         r_beat;
  logic                      r_out_valid;
  logic                      r_out_last;
  logic                      r_out_nan;
  logic [LANES*32-1:0]       r_out_data;

  logic                      w_in_ready;
  logic                      w_accept;
  logic                      w_advance;
  logic                      w_finish;
  logic [7:0]                w_src_scale;
  logic [BLOCK_SIZE*8-1:0]   w_src_block;
  logic [BEAT_W-1:0]         w_src_beat;
  logic [7:0]                w_src_elem [BLOCK_SIZE];
  logic [LANES*32-1:0]       w_conv;

  assign w_accept  = in_valid & w_in_ready;
  assign w_advance = r_out_valid & out_ready & ~r_out_last;
  assign w_finish  = r_out_valid & out_ready & r_out_last;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next state and input-side ready.
  always_comb begin
    w_state_nxt = r_state;
    w_in_ready  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_in_ready = 1'b1;
        if (in_valid) w_state_nxt = ST_STREAM;
      end
      ST_STREAM: begin
        if (w_finish) begin
          w_in_ready  = 1'b1;
          w_state_nxt = in_valid ? ST_STREAM : ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // The beat being registered next comes either from the block being
  // accepted (beat 0) or from the buffer (following beat).
  assign w_src_scale = w_accept ? in_scale    : r_scale;
  assign w_src_block = w_accept ? in_elements : r_elems;
  assign w_src_beat  = w_accept ? '0 : (r_beat + BEAT_W'(1));

  genvar gi;
  generate
    for (gi = 0; gi < BLOCK_SIZE; gi++) begin : g_split
      assign w_src_elem[gi] = w_src_block[gi*8 +: 8];
    end
    for (gi = 0; gi < LANES; gi++) begin : g_lane
      localparam logic [LANE_W-1:0] LANE_IDX = LANE_W'(gi);
      mxint8_elem_to_fp32 u_conv (
        .scale (w_src_scale),
        .elem  (w_src_elem[{w_src_beat, LANE_IDX}]),
        .fp32  (w_conv[gi*32 +: 32])
      );
    end
  endgenerate

  // Block buffer, beat counter and registered output beat.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_scale     <= '0;
      r_elems     <= '0;
      r_beat      <= '0;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
      r_out_nan   <= 1'b0;
      r_out_data  <= '0;
    end else if (w_accept) begin
      r_scale     <= in_scale;
      r_elems     <= in_elements;
      r_beat      <= '0;
      r_out_valid <= 1'b1;
      r_out_last  <= (BEATS == 1);
      r_out_nan   <= (in_scale == E8M0_NAN);
      r_out_data  <= w_conv;
    end else if (w_advance) begin
      r_beat      <= w_src_beat;
      r_out_last  <= (w_src_beat == BEAT_W'(BEATS - 1));
      r_out_data  <= w_conv;
    end else if (w_finish) begin
      r_out_valid <= 1'b0;
    end
  end

  assign in_ready  = w_in_ready;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_beat  = r_beat;
  assign out_last  = r_out_last;
  assign out_nan   = r_out_nan;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_mxint8_to_fp32_unpacker.sv
// Directed bench for the MXINT8 -> FP32 unpacker.
module tb_mxint8_to_fp32_unpacker;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [7:0]   in_scale;
  logic [255:0] in_elements;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_data;
  logic [2:0]   out_beat;
  logic         out_last;
  logic         out_nan;
  logic         dbg_state;

  mxint8_to_fp32_unpacker dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_scale    (in_scale),
    .in_elements (in_elements),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .out_beat    (out_beat),
    .out_last    (out_last),
    .out_nan     (out_nan),
    .dbg_state   (dbg_state)
  );

  // Clock and watchdog.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // Scoreboard.
  logic [31:0] exp_q[$];
  int          n_total = 0;
  int          n_bad   = 0;
  logic [7:0]  pv[8];
  logic [31:0] pe[8];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  task automatic set_pat(input int i, input logic [7:0] v, input logic [31:0] e);
    pv[i] = v;
    pe[i] = e;
  endtask

  // Element i takes pattern entry i % n; its hand-computed result is queued.
  task automatic make_block(input int n, output logic [255:0] el);
    for (int i = 0; i < 32; i++) begin
      el[i*8 +: 8] = pv[i % n];
      exp_q.push_back(pe[i % n]);
    end
  endtask

  task automatic check_lanes(input string tag);
    for (int j = 0; j < 4; j++) begin
      if (exp_q.size() == 0) chk({tag, "_queue_empty"}, 32'd1, 32'd0);
      else chk($sformatf("%s_lane%0d", tag, j), out_data[j*32 +: 32], exp_q.pop_front());
    end
  endtask

  // Drives a block from idle; returns at the negedge showing beat 0.
  task automatic send(input logic [7:0] s, input logic [255:0] el);
    int n;
    n = 0;
    in_valid    = 1'b1;
    in_scale    = s;
    in_elements = el;
    while (!in_ready && n < 64) begin
      @(negedge clk);
      n++;
    end
    chk("accept_wait", 32'(n < 64), 32'd1);
    chk("idle_out_valid", 32'(out_valid), 32'd0);
    @(negedge clk);
    in_valid    = 1'b0;
    in_scale    = 8'($urandom);
    in_elements = {8{32'($urandom)}};
    chk("latency1_valid", 32'(out_valid), 32'd1);
  endtask

  // Consumes beats from the current negedge; optional stall and early stop.
  task automatic drain(input logic nan, input int stall_beat, input int stop_beat);
    logic [127:0] held;
    for (int b = 0; b < 8; b++) begin
      if (b == stop_beat) return;
      chk($sformatf("valid_b%0d", b), 32'(out_valid), 32'd1);
      chk($sformatf("beat_b%0d", b), 32'(out_beat), 32'(b));
      chk($sformatf("last_b%0d", b), 32'(out_last), 32'(b == 7));
      chk($sformatf("nan_b%0d", b), 32'(out_nan), 32'(nan));
      check_lanes($sformatf("data_b%0d", b));
      if (b == stall_beat) begin
        held      = out_data;
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
          @(negedge clk);
          chk($sformatf("stall%0d_valid", k), 32'(out_valid), 32'd1);
          chk($sformatf("stall%0d_beat", k), 32'(out_beat), 32'(b));
          chk($sformatf("stall%0d_last", k), 32'(out_last), 32'(b == 7));
          for (int j = 0; j < 4; j++)
            chk($sformatf("stall%0d_data%0d", k, j), out_data[j*32 +: 32], held[j*32 +: 32]);
        end
        out_ready = 1'b1;
      end
      @(negedge clk);
    end
  endtask

  task automatic pat_basic();
    set_pat(0, 8'h40, 32'h3F80_0000);
    set_pat(1, 8'hC0, 32'hBF80_0000);
    set_pat(2, 8'h01, 32'h3C80_0000);
    set_pat(3, 8'h00, 32'h0000_0000);
    set_pat(4, 8'h7F, 32'h3FFE_0000);
  endtask

  task automatic pat_sub();
    set_pat(0, 8'h01, 32'h0001_0000);
    set_pat(1, 8'hFF, 32'h8001_0000);
    set_pat(2, 8'h80, 32'h8080_0000);
    set_pat(3, 8'h40, 32'h0040_0000);
  endtask

  logic [255:0] blk;
  logic [255:0] blk_b;
  int           seen;

  initial begin
    rst         = 1'b1;
    in_valid    = 1'b0;
    in_scale    = 8'h00;
    in_elements = '0;
    out_ready   = 1'b1;

    // Reset state.
    repeat (3) @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", out_data[31:0] | out_data[63:32] | out_data[95:64] | out_data[127:96], 32'd0);
    chk("rst_out_beat", 32'(out_beat), 32'd0);
    chk("rst_out_last", 32'(out_last), 32'd0);
    chk("rst_out_nan", 32'(out_nan), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    rst = 1'b0;
    @(negedge clk);

    // Basic values at S=127, with a 3-cycle stall on beat 2.
    pat_basic();
    make_block(5, blk);
    send(8'd127, blk);
    drain(1'b0, 2, 99);
    chk("basic_done_valid", 32'(out_valid), 32'd0);

    // NaN scale with random elements, then a normal block clears out_nan.
    for (int i = 0; i < 32; i++) begin
      blk[i*8 +: 8] = 8'($urandom);
      exp_q.push_back(32'h7FC0_0000);
    end
    send(8'hFF, blk);
    drain(1'b1, -1, 99);
    pat_basic();
    make_block(5, blk);
    send(8'd127, blk);
    drain(1'b0, -1, 99);

    // Extremes at the top of the exponent range.
    set_pat(0, 8'h80, 32'hFF80_0000);
    set_pat(1, 8'h7F, 32'h7F7E_0000);
    make_block(2, blk);
    send(8'd254, blk);
    drain(1'b0, -1, 99);
    set_pat(0, 8'h80, 32'hFF00_0000);
    set_pat(1, 8'h00, 32'h0000_0000);
    make_block(2, blk);
    send(8'd253, blk);
    drain(1'b0, -1, 99);

    // Subnormals and the smallest normal at S=0.
    pat_sub();
    make_block(4, blk);
    send(8'd0, blk);
    drain(1'b0, -1, 99);

    // Back-to-back: block B offered from A's beat 3, enters on A's last beat.
    pat_basic();
    make_block(5, blk);
    pat_sub();
    make_block(4, blk_b);
    send(8'd127, blk);
    for (int b = 0; b < 8; b++) begin
      chk($sformatf("b2b_beat%0d", b), 32'(out_beat), 32'(b));
      check_lanes($sformatf("b2b_a_b%0d", b));
      if (b >= 3) begin
        in_valid    = 1'b1;
        in_scale    = 8'd0;
        in_elements = blk_b;
      end
      chk($sformatf("b2b_in_ready%0d", b), 32'(in_ready), 32'(b == 7));
      @(negedge clk);
    end
    in_valid = 1'b0;
    chk("b2b_no_bubble_valid", 32'(out_valid), 32'd1);
    chk("b2b_no_bubble_beat", 32'(out_beat), 32'd0);
    drain(1'b0, -1, 99);
    chk("b2b_done_valid", 32'(out_valid), 32'd0);
    chk("queue_empty", 32'(exp_q.size()), 32'd0);

    // Reset mid-block at beat 4.
    pat_basic();
    make_block(5, blk);
    send(8'd127, blk);
    drain(1'b0, -1, 4);
    rst = 1'b1;
    #1;
    chk("mid_rst_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_data", out_data[31:0] | out_data[63:32] | out_data[95:64] | out_data[127:96], 32'd0);
    chk("mid_rst_beat", 32'(out_beat), 32'd0);
    chk("mid_rst_last", 32'(out_last), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("post_rst_in_ready", 32'(in_ready), 32'd1);
    seen = 0;
    repeat (12) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    chk("post_rst_no_beats", 32'(seen), 32'd0);
    exp_q.delete();

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
